// File: rtl/alarm_tone_sequencer_if.sv
// Alarm tone sequencer bus bundle: control inputs, sample ROM port,
// and the sample stream that feeds the PDM stage.
// The master side is the sequencer. The slave side is the surrounding system
// (the alarm comparator, the ROM and the PDM modulator).
interface alarm_tone_sequencer_if #(
  parameter int ADDR_W = 15
) ();

  // Control from the alarm comparator
  logic              trigger;
  logic              stop;
  logic [1:0]        vol;

  // Synchronous sample ROM port
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_data;

  // Sample stream towards the PDM modulator, plus status
  logic [15:0]       sample_out;
  logic              sample_valid;
  logic              busy;
  logic              done;

  modport master (
    input  trigger,
    input  stop,
    input  vol,
    input  rom_data,
    output rom_addr,
    output sample_out,
    output sample_valid,
    output busy,
    output done
  );

  modport slave (
    output trigger,
    output stop,
    output vol,
    output rom_data,
    input  rom_addr,
    input  sample_out,
    input  sample_valid,
    input  busy,
    input  done
  );

endinterface

// File: rtl/alarm_tone_sequencer.sv
// Alarm tone sequencer.
// A rising edge on trigger starts playback. Playback steps a synchronous
// sample ROM once every DIV clocks. Each fetched sample is attenuated by an
// arithmetic right shift of vol bits and presented to the PDM stage with a
// one-cycle valid strobe. Playback runs for REPEATS passes over the ROM, or
// loops until stop when REPEATS is 0. stop aborts playback immediately.
module alarm_tone_sequencer #(
  parameter int CLK_HZ      = 50000000,
  parameter int SAMPLE_HZ   = 8000,
  parameter int NUM_SAMPLES = 19832,
  parameter int ADDR_W      = 15,
  parameter int REPEATS     = 3
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  alarm_tone_sequencer_if.master   bus
);

  // Clocks per sample period. This must be an integer of at least 4 so that
  // the two-cycle ROM/scale pipeline finishes well inside one period.
  localparam int DIV   = CLK_HZ / SAMPLE_HZ;
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int REP_W = (REPEATS > 1) ? $clog2(REPEATS + 1) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(NUM_SAMPLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'((REPEATS == 0) ? 0 : REPEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q,        state_d;
  logic [ADDR_W-1:0] rom_addr_q,     rom_addr_d;
  logic [DIV_W-1:0]  div_cnt_q,      div_cnt_d;
  logic [REP_W-1:0]  rep_cnt_q,      rep_cnt_d;
  logic              trigger_q;
  logic              fetch_q,        fetch_d;
  logic              fetch_dly_q,    fetch_dly_d;
  logic [15:0]       sample_out_q,   sample_out_d;
  logic              sample_valid_q, sample_valid_d;
  logic              busy_q,         busy_d;
  logic              done_q,         done_d;

  logic              start;
  logic              end_play;
  logic signed [15:0] scaled;

  // Only a fresh 0->1 transition of trigger starts playback. trigger_q resets
  // high, so a trigger that is already high at reset release is ignored.
  assign start = bus.trigger & ~trigger_q;

  // The ROM word arriving this cycle, attenuated with sign preserved. The
  // shift rounds toward minus infinity.
  assign scaled = $signed(bus.rom_data) >>> bus.vol;

  // Next-state, counter and output logic for IDLE -> PLAY -> DRAIN -> IDLE
  always_comb begin
    state_d        = state_q;
    rom_addr_d     = rom_addr_q;
    div_cnt_d      = div_cnt_q;
    rep_cnt_d      = rep_cnt_q;
    fetch_d        = 1'b0;
    fetch_dly_d    = fetch_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    busy_d         = busy_q;
    done_d         = 1'b0;
    end_play       = 1'b0;

    // Second pipeline stage: the ROM word for the address issued two cycles
    // ago is valid now, so scale it and publish it.
    if (fetch_dly_q) begin
      sample_out_d   = scaled;
      sample_valid_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start && !bus.stop) begin
          state_d    = PLAY;
          rom_addr_d = '0;
          div_cnt_d  = '0;
          rep_cnt_d  = '0;
          busy_d     = 1'b1;
          fetch_d    = 1'b1;
        end
      end

      PLAY: begin
        if (bus.stop) begin
          end_play = 1'b1;
        end else if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (rom_addr_q != ADDR_LAST) begin
            rom_addr_d = rom_addr_q + 1'b1;
            fetch_d    = 1'b1;
          end else begin
            if (REPEATS != 0) begin
              rep_cnt_d = rep_cnt_q + 1'b1;
            end
            if ((REPEATS != 0) && (rep_cnt_q == REP_LAST)) begin
              end_play = 1'b1;
            end else begin
              rom_addr_d = '0;
              fetch_d    = 1'b1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      DRAIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Leaving PLAY, for a normal end or for an abort, silences the output and
    // drops any fetch still in flight. The done strobe and the fall of busy
    // appear on the same edge.
    if (end_play) begin
      state_d        = DRAIN;
      fetch_d        = 1'b0;
      fetch_dly_d    = 1'b0;
      sample_out_d   = '0;
      sample_valid_d = 1'b0;
      busy_d         = 1'b0;
      done_d         = 1'b1;
    end
  end

  // State, counters, fetch pipeline and registered outputs
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rom_addr_q     <= '0;
      div_cnt_q      <= '0;
      rep_cnt_q      <= '0;
      trigger_q      <= 1'b1;
      fetch_q        <= 1'b0;
      fetch_dly_q    <= 1'b0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      rom_addr_q     <= rom_addr_d;
      div_cnt_q      <= div_cnt_d;
      rep_cnt_q      <= rep_cnt_d;
      trigger_q      <= bus.trigger;
      fetch_q        <= fetch_d;
      fetch_dly_q    <= fetch_dly_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign bus.rom_addr     = rom_addr_q;
  assign bus.sample_out   = sample_out_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;

endmodule
